octal_digit_serializer: RTL and testbench

- Upstream feeder for the 3-to-8 one-hot decoder stage.
- Accepts a WIDTH-bit binary word through a valid/ready handshake and zero-extends it to a whole number of octal digits.
- Emits the word one octal digit per handshake, most significant digit first.
- Each digit is presented as three separate bits, out_a (MSB), out_b and out_c (LSB), so it wires directly to the decoder's A/B/C inputs.

---
 rtl/octal_pkg.sv | 21 ++
 rtl/octal_digit_serializer.sv | 120 ++++++++++++
 tb/tb_octal_digit_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/octal_pkg.sv
// octal_pkg
//   Shared definitions for the octal digit serializer:
//     DIGIT_W - bits per octal digit
//     state_e - serializer FSM states (IDLE, SKIP, EMIT)
//     ndig()  - number of octal digits needed to cover a binary word
package octal_pkg;

  localparam int DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    EMIT = 2'd2
  } state_e;

  // Digits needed to hold a 'width'-bit word (ceil(width/3)).
  function automatic int ndig(input int width);
    return (width + DIGIT_W - 1) / DIGIT_W;
  endfunction

endpackage : octal_pkg

// File: rtl/octal_digit_serializer.sv
// octal_digit_serializer
//   Accepts a WIDTH-bit binary word over a valid/ready handshake, zero-extends
//   it to NDIG octal digits and emits one digit per output handshake, most
//   significant digit first. Each digit is split into out_a (MSB), out_b and
//   out_c (LSB) so it drives a 3-to-8 one-hot decoder directly.
//
// Parameters
//   WIDTH       - binary input word width (>= 1)
//   SUPPRESS_LZ - 1: skip leading zero digits (digit 0 is always emitted)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_data is valid
//   in_ready   out  block can accept a word (only in IDLE)
//   in_data    in   WIDTH-bit word to convert
//   out_valid  out  digit on out_a/b/c is valid (only in EMIT)
//   out_ready  in   downstream accepts the digit
//   out_a/b/c  out  digit bits 2/1/0
//   out_idx    out  digit position, NDIG-1 = most significant
//   out_last   out  current digit is digit 0
//   busy       out  a word is held
module octal_digit_serializer
  import octal_pkg::*;
#(
  parameter  int WIDTH       = 12,
  parameter  bit SUPPRESS_LZ = 1'b0,
  localparam int NDIG        = ndig(WIDTH),
  localparam int IDXW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_c,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int              SRW     = DIGIT_W * NDIG;
  localparam logic [IDXW-1:0] CNT_TOP = IDXW'(NDIG - 1);
  localparam logic [IDXW-1:0] CNT_ONE = IDXW'(1);

  state_e              state_q, state_d;
  logic [SRW-1:0]      sr_q, sr_d;
  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  top_digit;
  logic                cnt_zero;

  // The digit being presented is always the top of the shift register.
  assign top_digit = sr_q[SRW-1 -: DIGIT_W];
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = SRW'(in_data);
          cnt_d   = CNT_TOP;
          state_d = SUPPRESS_LZ ? SKIP : EMIT;
        end
      end
      SKIP: begin
        // Drop one leading zero per cycle; digit 0 is never dropped, so an
        // all-zero word still produces a single '0'.
        if ((top_digit == '0) && !cnt_zero) begin
          sr_d  = sr_q << DIGIT_W;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!cnt_zero) begin
            sr_d  = sr_q << DIGIT_W;
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags come from state alone; digit fields come straight from
  // registers, so there is no input-to-output combinational path and the
  // digit stays put while out_ready is low.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_a     = top_digit[2];
  assign out_b     = top_digit[1];
  assign out_c     = top_digit[0];
  assign out_idx   = cnt_q;
  assign out_last  = (state_q == EMIT) && cnt_zero;

endmodule : octal_digit_serializer

// File: tb/tb_octal_digit_serializer.sv
// Directed bench for octal_digit_serializer. Three instances:
//   u0: WIDTH=12, no suppression; u1: WIDTH=8, no suppression;
//   u2: WIDTH=12, leading-zero suppression.
module tb_octal_digit_serializer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  irdy;
  logic [2:0]  ovld;
  logic [2:0]  oa, ob, oc;
  logic [2:0]  olast;
  logic [2:0]  obusy;
  logic [1:0]  oidx0, oidx1, oidx2;
  logic [11:0] d0;
  logic [7:0]  d1;
  logic [11:0] d2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  octal_digit_serializer #(.WIDTH(12), .SUPPRESS_LZ(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(d0),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]),
    .out_idx(oidx0), .out_last(olast[0]), .busy(obusy[0]));

  octal_digit_serializer #(.WIDTH(8), .SUPPRESS_LZ(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(d1),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]),
    .out_idx(oidx1), .out_last(olast[1]), .busy(obusy[1]));

  octal_digit_serializer #(.WIDTH(12), .SUPPRESS_LZ(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(d2),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .out_a(oa[2]), .out_b(ob[2]), .out_c(oc[2]),
    .out_idx(oidx2), .out_last(olast[2]), .busy(obusy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] dig(input int u);
    return {oa[u], ob[u], oc[u]};
  endfunction

  function automatic logic [1:0] idx(input int u);
    case (u)
      0:       return oidx0;
      1:       return oidx1;
      default: return oidx2;
    endcase
  endfunction

  // Present one word for a single accept cycle.
  task automatic send(input int u, input logic [11:0] w);
    case (u)
      0:       d0 = w;
      1:       d1 = w[7:0];
      default: d2 = w;
    endcase
    iv[u] = 1'b1;
    tick();
    iv[u] = 1'b0;
  endtask

  task automatic expect_digit(input int u, input string tag, input int d, input int i, input bit last);
    check({tag, "_valid"}, 32'(ovld[u]), 32'd1);
    check({tag, "_digit"}, 32'(dig(u)), 32'(d));
    check({tag, "_idx"},   32'(idx(u)), 32'(i));
    check({tag, "_last"},  32'(olast[u]), 32'(last));
  endtask

  task automatic expect_idle(input int u, input string tag);
    check({tag, "_in_ready"},  32'(irdy[u]), 32'd1);
    check({tag, "_out_valid"}, 32'(ovld[u]), 32'd0);
    check({tag, "_busy"},      32'(obusy[u]), 32'd0);
  endtask

  initial begin
    int exp7531 [4];
    int exp6420 [4];
    exp7531 = '{7, 5, 3, 1};
    exp6420 = '{6, 4, 2, 0};
    rst_n = 1'b0;
    iv    = '0;
    ordy  = 3'b111;
    d0 = '0; d1 = '0; d2 = '0;
    tick();
    tick();

    // Reset values
    expect_idle(0, "rst");
    check("rst_digit", 32'(dig(0)), 32'd0);
    check("rst_idx",   32'(oidx0), 32'd0);
    check("rst_last",  32'(olast[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // 12'o7531 streamed with out_ready held high
    send(0, 12'o7531);
    check("t1_in_ready_busy", 32'(irdy[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      expect_digit(0, $sformatf("t1_d%0d", k), exp7531[k], 3 - k, k == 3);
      tick();
    end
    expect_idle(0, "t1_end");

    // Backpressure while digit 5 is shown
    send(0, 12'o7531);
    expect_digit(0, "t2_d0", 7, 3, 1'b0);
    tick();
    ordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_digit(0, $sformatf("t2_hold%0d", k), 5, 2, 1'b0);
      tick();
    end
    ordy[0] = 1'b1;
    expect_digit(0, "t2_d1", 5, 2, 1'b0);
    tick();
    expect_digit(0, "t2_d2", 3, 1, 1'b0);
    tick();
    expect_digit(0, "t2_d3", 1, 0, 1'b1);
    tick();
    expect_idle(0, "t2_end");

    // WIDTH=8, 8'hFF -> 0o377
    send(1, 12'h0FF);
    expect_digit(1, "t3_d0", 3, 2, 1'b0);
    tick();
    expect_digit(1, "t3_d1", 7, 1, 1'b0);
    tick();
    expect_digit(1, "t3_d2", 7, 0, 1'b1);
    tick();
    expect_idle(1, "t3_end");

    // Suppression: 12'o0042. SKIP examines cnt=3 (0), cnt=2 (0), cnt=1 (4)
    // before EMIT, so out_valid stays low for three cycles.
    send(2, 12'o0042);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_skip%0d_valid", k), 32'(ovld[2]), 32'd0);
      check($sformatf("t4_skip%0d_busy", k),  32'(obusy[2]), 32'd1);
      tick();
    end
    expect_digit(2, "t4_d0", 4, 1, 1'b0);
    tick();
    expect_digit(2, "t4_d1", 2, 0, 1'b1);
    tick();
    expect_idle(2, "t4_end");

    // Suppression: all-zero word -> four silent cycles, then a single 0.
    send(2, 12'o0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_skip%0d_valid", k), 32'(ovld[2]), 32'd0);
      tick();
    end
    expect_digit(2, "t5_d0", 0, 0, 1'b1);
    tick();
    expect_idle(2, "t5_end");

    // in_valid during emission is ignored
    send(0, 12'o7531);
    expect_digit(0, "t6_d0", 7, 3, 1'b0);
    d0 = 12'o1111;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    expect_digit(0, "t6_d1", 5, 2, 1'b0);
    tick();
    expect_digit(0, "t6_d2", 3, 1, 1'b0);
    tick();
    expect_digit(0, "t6_d3", 1, 0, 1'b1);
    tick();
    expect_idle(0, "t6_end");

    // Reset after digit 7 is taken, then a fresh word
    send(0, 12'o7531);
    expect_digit(0, "t7_d0", 7, 3, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_idle(0, "t7_rst");
    check("t7_rst_digit", 32'(dig(0)), 32'd0);
    check("t7_rst_idx",   32'(oidx0), 32'd0);
    check("t7_rst_last",  32'(olast[0]), 32'd0);
    tick();
    expect_idle(0, "t7_post");
    send(0, 12'o6420);
    for (int k = 0; k < 4; k++) begin
      expect_digit(0, $sformatf("t7_n%0d", k), exp6420[k], 3 - k, k == 3);
      tick();
    end
    expect_idle(0, "t7_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_octal_digit_serializer
